// File: rtl/system_top_cmul_pipe.sv
// Three-stage signed complex multiplier (a*b or a*conj(b)) with round-half-up
// shift and saturation, valid/ready streaming with a global advance enable.

module cmul_rnd_sat #(
  parameter int CW    = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [CW-1:0]    x_i,
  output logic        [OUT_W-1:0] y_o,
  output logic                    sat_o
);
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = ~MAXV;

  logic signed [CW-1:0] r;

  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [CW-1:0] HALF = {{(CW-1){1'b0}}, 1'b1} << (SHIFT-1);
      // Headroom of two extra bits keeps the rounding add from wrapping.
      logic signed [CW-1:0] sum;
      assign sum = x_i + HALF;
      assign r   = sum >>> SHIFT;
    end else begin : g_nornd
      assign r = x_i;
    end
  endgenerate

  always_comb begin
    y_o   = r[OUT_W-1:0];
    sat_o = 1'b0;
    if (r > MAXV) begin
      y_o   = MAXV[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (r < MINV) begin
      y_o   = MINV[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

module system_top_cmul_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    conj_en,
  input  logic signed [IN_W-1:0]  a_re,
  input  logic signed [IN_W-1:0]  a_im,
  input  logic signed [IN_W-1:0]  b_re,
  input  logic signed [IN_W-1:0]  b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y_re,
  output logic signed [OUT_W-1:0] y_im,
  output logic                    y_sat
);
  localparam int PW = 2*IN_W;
  localparam int CW = 2*IN_W + 2;

  function automatic logic signed [PW-1:0] sx(input logic signed [IN_W-1:0] v);
    return {{IN_W{v[IN_W-1]}}, v};
  endfunction

  logic [3:1] vld_pipe_q;
  logic       en;

  assign en        = out_ready | ~vld_pipe_q[3];
  assign in_ready  = en;
  assign out_valid = vld_pipe_q[3];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)  vld_pipe_q <= '0;
    else if (en)    vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
  end

  // S1: operand capture
  logic signed [IN_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic                   cj1_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      a_re_q <= '0; a_im_q <= '0; b_re_q <= '0; b_im_q <= '0; cj1_q <= 1'b0;
    end else if (en && in_valid) begin
      a_re_q <= a_re; a_im_q <= a_im; b_re_q <= b_re; b_im_q <= b_im; cj1_q <= conj_en;
    end
  end

  // S2: four partial products at full precision
  logic signed [PW-1:0] pp_d, qq_d, pq_d, qp_d;
  logic signed [PW-1:0] pp_q, qq_q, pq_q, qp_q;
  logic                 cj2_q;

  assign pp_d = sx(a_re_q) * sx(b_re_q);
  assign qq_d = sx(a_im_q) * sx(b_im_q);
  assign pq_d = sx(a_re_q) * sx(b_im_q);
  assign qp_d = sx(a_im_q) * sx(b_re_q);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      pp_q <= '0; qq_q <= '0; pq_q <= '0; qp_q <= '0; cj2_q <= 1'b0;
    end else if (en && vld_pipe_q[1]) begin
      pp_q <= pp_d; qq_q <= qq_d; pq_q <= pq_d; qp_q <= qp_d; cj2_q <= cj1_q;
    end
  end

  // S3: combine, round/shift, saturate; index 0 = re, 1 = im
  logic signed [CW-1:0]     ppx, qqx, pqx, qpx;
  logic [1:0][CW-1:0]       cmb;
  logic [1:0][OUT_W-1:0]    y_d;
  logic [1:0]               sat_d;

  assign ppx = {{2{pp_q[PW-1]}}, pp_q};
  assign qqx = {{2{qq_q[PW-1]}}, qq_q};
  assign pqx = {{2{pq_q[PW-1]}}, pq_q};
  assign qpx = {{2{qp_q[PW-1]}}, qp_q};

  assign cmb[0] = cj2_q ? (ppx + qqx) : (ppx - qqx);
  assign cmb[1] = cj2_q ? (qpx - pqx) : (pqx + qpx);

  generate
    for (genvar g = 0; g < 2; g++) begin : g_comp
      cmul_rnd_sat #(.CW(CW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs (
        .x_i   (cmb[g]),
        .y_o   (y_d[g]),
        .sat_o (sat_d[g])
      );
    end
  endgenerate

  logic [OUT_W-1:0] y_re_q, y_im_q;
  logic             sat_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      y_re_q <= '0; y_im_q <= '0; sat_q <= 1'b0;
    end else if (en && vld_pipe_q[2]) begin
      y_re_q <= y_d[0]; y_im_q <= y_d[1]; sat_q <= |sat_d;
    end
  end

  assign y_re  = y_re_q;
  assign y_im  = y_im_q;
  assign y_sat = sat_q;
endmodule

// File: tb/tb_system_top_cmul_pipe.sv
// Directed bench for system_top_cmul_pipe: default build plus a full-precision
// build (OUT_W=34, SHIFT=0) driven in lockstep from shared inputs.

module tb_system_top_cmul_pipe;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, in_valid = 1'b0, conj_en = 1'b0, out_ready = 1'b1;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  logic               in_ready, out_valid, y_sat;
  logic signed [15:0] y_re, y_im;
  logic               in_ready_w, out_valid_w, y_sat_w;
  logic signed [33:0] y_re_w, y_im_w;

  int checks = 0, errors = 0;

  always #5 ap_clk = ~ap_clk;

  system_top_cmul_pipe u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .conj_en(conj_en), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im), .y_sat(y_sat)
  );

  system_top_cmul_pipe #(.IN_W(16), .OUT_W(34), .SHIFT(0)) u_dut_w (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .conj_en(conj_en), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid_w), .out_ready(out_ready), .y_re(y_re_w), .y_im(y_im_w), .y_sat(y_sat_w)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi, input bit cj);
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    conj_en = cj; in_valid = 1'b1;
  endtask

  // One isolated sample through the default build, unstalled.
  task automatic run1(input string tag, input int ar, input int ai, input int br, input int bi,
                      input bit cj, input longint er, input longint ei, input longint es);
    int lat;
    drive(ar, ai, br, bi, cj);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_re"},  y_re, er);
    chk({tag, "_im"},  y_im, ei);
    chk({tag, "_sat"}, y_sat, es);
    step();
  endtask

  function automatic longint rs(input longint x, output bit s);
    longint r;
    r = (x + 64'sd16384) >>> 15;
    s = 1'b1;
    if (r > 32767)       return 32767;
    else if (r < -32768) return -32768;
    s = 1'b0;
    return r;
  endfunction

  task automatic model(input int ar, input int ai, input int br, input int bi, input bit cj,
                       output longint er, output longint ei, output longint es);
    longint pp, qq, pq, qp, re, im;
    bit s1, s2;
    pp = longint'(ar) * br; qq = longint'(ai) * bi;
    pq = longint'(ar) * bi; qp = longint'(ai) * br;
    re = cj ? pp + qq : pp - qq;
    im = cj ? qp - pq : pq + qp;
    er = rs(re, s1);
    ei = rs(im, s2);
    es = longint'(s1 | s2);
  endtask

  initial begin
    int     lat, sent, got, cyc, stale;
    int     sa[10][4];
    bit     sc[10];
    longint q_re[$], q_im[$], q_s[$];
    longint er, ei, es;
    logic [3:1] mv;
    logic       en_exp;

    // Reset state
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_re", y_re, 0);
    chk("rst_im", y_im, 0);
    chk("rst_sat", y_sat, 0);
    chk("rst_ready", in_ready, 1);
    ap_rst_n = 1'b1;
    step();

    run1("basic", 16384, 0, 16384, 0, 0, 8192, 0, 0);

    run1("rnd_half_up",  1, 0, 16384, 0, 0,  1, 0, 0);
    run1("rnd_below",    1, 0, 16383, 0, 0,  0, 0, 0);
    run1("rnd_neg_half", -1, 0, 16384, 0, 0, 0, 0, 0);
    run1("rnd_neg",      -1, 0, 16385, 0, 0, -1, 0, 0);

    run1("sat_re",     -32768, 0, -32768, 0, 0, 32767, 0, 1);
    run1("sat_corner", -32768, -32768, -32768, -32768, 0, 0, 32767, 1);
    run1("sat_conj",   -32768, -32768, -32768, -32768, 1, 32767, 0, 1);

    // Back-to-back a*b then a*conj(b) through the full-precision build
    drive(100, 200, 300, 400, 0);
    step();
    drive(100, 200, 300, 400, 1);
    step();
    in_valid = 1'b0;
    lat = 2;
    while (!out_valid_w && lat < 10) begin
      step();
      lat++;
    end
    chk("cplx_lat", lat, 3);
    chk("cplx_re", y_re_w, -50000);
    chk("cplx_im", y_im_w, 100000);
    chk("cplx_sat", y_sat_w, 0);
    step();
    chk("conj_valid", out_valid_w, 1);
    chk("conj_re", y_re_w, 110000);
    chk("conj_im", y_im_w, 20000);
    step();

    // Back-pressure stream against a spec-level occupancy model
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) sa[i][k] = int'($urandom_range(0, 65535)) - 32768;
      sc[i] = bit'($urandom_range(0, 1));
    end
    for (int k = 0; k < 4; k++) sa[0][k] = -32768;
    sent = 0; got = 0; cyc = 0; mv = '0;
    while (got < 10 && cyc < 300) begin
      out_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (sent < 10) drive(sa[sent][0], sa[sent][1], sa[sent][2], sa[sent][3], sc[sent]);
      else           in_valid = 1'b0;
      #1;
      en_exp = out_ready | ~mv[3];
      chk("bp_valid", out_valid, mv[3]);
      chk("bp_ready", in_ready, en_exp);
      if (out_valid) begin
        if (q_re.size() == 0) chk("bp_extra", 1, 0);
        else begin
          chk("bp_re", y_re, q_re[0]);
          chk("bp_im", y_im, q_im[0]);
          chk("bp_sat", y_sat, q_s[0]);
        end
      end
      if (in_valid && en_exp) begin
        model(sa[sent][0], sa[sent][1], sa[sent][2], sa[sent][3], sc[sent], er, ei, es);
        q_re.push_back(er); q_im.push_back(ei); q_s.push_back(es);
        sent++;
      end
      if (out_valid && out_ready && q_re.size() != 0) begin
        void'(q_re.pop_front()); void'(q_im.pop_front()); void'(q_s.pop_front());
        got++;
      end
      if (en_exp) mv = {mv[2:1], in_valid};
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    chk("bp_done", got, 10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Reset with three samples in flight
    drive(1000, 0, 16384, 0, 0);
    step();
    drive(2000, 0, 16384, 0, 0);
    step();
    drive(3000, 0, 16384, 0, 0);
    step();
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    chk("mid_valid", out_valid, 0);
    chk("mid_re", y_re, 0);
    chk("mid_im", y_im, 0);
    stale = 0;
    repeat (5) begin
      step();
      if (out_valid) stale++;
    end
    chk("mid_stale", stale, 0);
    run1("post_rst", 16384, 0, 16384, 0, 0, 8192, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
